// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for a single-port SRAM with a registered
// BIST port, one-cycle read latency, and sticky pass/fail reporting.
module mbist_march_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48,
  parameter int DEPTH  = 256
) (
  input  logic              A_CLK,
  input  logic              A_RST_N,
  input  logic              START,
  output logic              A_BIST_EN,
  output logic              A_BIST_MEN,
  output logic              A_BIST_WEN,
  output logic              A_BIST_REN,
  output logic [ADDR_W-1:0] A_BIST_ADDR,
  output logic [DATA_W-1:0] A_BIST_DIN,
  output logic [DATA_W-1:0] A_BIST_BM,
  input  logic [DATA_W-1:0] A_DOUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [7:0]        FAIL_CNT,
  output logic [1:0]        dbg_state
);

  // Handshake: START is a single-cycle request sampled on the rising edge; it is
  // accepted only in ST_IDLE or ST_DONE and is ignored while BUSY is high.

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [2:0]          elem;
  logic                op;
  logic [ADDR_W-1:0]   addr;
  logic                fin;

  // Two-stage compare pipeline: stage 1 travels with the read access, stage 2
  // lines up with the cycle in which A_DOUT carries that read's data.
  logic                rd_vld1, rd_vld2;
  logic [DATA_W-1:0]   rd_exp1, rd_exp2;
  logic [ADDR_W-1:0]   rd_addr1, rd_addr2;

  logic                is_read;
  logic                dbit;
  logic                op_last;
  logic                down;
  logic                addr_last;
  logic                elem_last;
  logic                test_last;
  logic [ADDR_W-1:0]   next_start;

  always_comb begin
    is_read = 1'b0;
    dbit    = 1'b0;
    case (elem)
      3'd0:    begin is_read = 1'b0; dbit = 1'b0; end
      3'd1:    begin is_read = ~op;  dbit = op;   end
      3'd2:    begin is_read = ~op;  dbit = ~op;  end
      3'd3:    begin is_read = ~op;  dbit = op;   end
      3'd4:    begin is_read = ~op;  dbit = ~op;  end
      default: begin is_read = 1'b1; dbit = 1'b0; end
    endcase
    op_last    = (elem == 3'd0 || elem == 3'd5) ? 1'b1 : op;
    down       = (elem == 3'd3 || elem == 3'd4);
    addr_last  = down ? (addr == '0) : (addr == LAST_ADDR);
    elem_last  = op_last && addr_last;
    test_last  = elem_last && (elem == 3'd5);
    next_start = (elem == 3'd2 || elem == 3'd3) ? LAST_ADDR : '0;
  end

  assign A_BIST_EN = BUSY;
  assign A_BIST_BM = {DATA_W{1'b1}};
  assign dbg_state = state;

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state       <= ST_IDLE;
      elem        <= '0;
      op          <= 1'b0;
      addr        <= '0;
      fin         <= 1'b0;
      rd_vld1     <= 1'b0;
      rd_vld2     <= 1'b0;
      rd_exp1     <= '0;
      rd_exp2     <= '0;
      rd_addr1    <= '0;
      rd_addr2    <= '0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FAIL        <= 1'b0;
      FAIL_ADDR   <= '0;
      FAIL_CNT    <= '0;
    end else begin
      rd_vld2    <= rd_vld1;
      rd_exp2    <= rd_exp1;
      rd_addr2   <= rd_addr1;
      rd_vld1    <= 1'b0;
      A_BIST_MEN <= 1'b0;
      A_BIST_WEN <= 1'b0;
      A_BIST_REN <= 1'b0;

      if (rd_vld2 && (A_DOUT != rd_exp2)) begin
        FAIL <= 1'b1;
        if (!FAIL) FAIL_ADDR <= rd_addr2;
        if (FAIL_CNT != 8'hFF) FAIL_CNT <= FAIL_CNT + 8'd1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state     <= ST_RUN;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_CNT  <= '0;
            FAIL_ADDR <= '0;
            elem      <= '0;
            op        <= 1'b0;
            addr      <= '0;
            fin       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (fin) begin
            state <= ST_DRAIN;
          end else begin
            A_BIST_MEN  <= 1'b1;
            A_BIST_WEN  <= ~is_read;
            A_BIST_REN  <= is_read;
            A_BIST_ADDR <= addr;
            A_BIST_DIN  <= {DATA_W{dbit}};
            if (is_read) begin
              rd_vld1  <= 1'b1;
              rd_exp1  <= {DATA_W{dbit}};
              rd_addr1 <= addr;
            end
            // Operation index first, then address, then element.
            if (test_last) begin
              fin <= 1'b1;
            end else if (elem_last) begin
              elem <= elem + 3'd1;
              op   <= 1'b0;
              addr <= next_start;
            end else if (op_last) begin
              op   <= 1'b0;
              addr <= down ? addr - 1'b1 : addr + 1'b1;
            end else begin
              op <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
